otter_uart_io: RTL



---
 rtl/otter_io_pkg.sv | 30 +++
 rtl/otter_io_if.sv | 18 +
 rtl/otter_sync_fifo.sv | 48 ++++
 rtl/otter_uart_io.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared constants and state types for the OTTER UART peripheral.
// Register addresses, STATUS bit positions, TX/RX FSM encodings.
package otter_io_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h1100_0040;
  localparam logic [31:0] ADDR_STATUS = 32'h1100_0044;
  localparam logic [31:0] ADDR_RXDATA = 32'h1100_0048;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVR   = 5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/otter_io_if.sv
// OTTER I/O bus bundle: address, write data, write strobe, read data.
// master = core side, slave = peripheral side.
interface otter_io_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;

  modport master (
    output iobus_addr, iobus_out, iobus_wr,
    input  iobus_in
  );

  modport slave (
    input  iobus_addr, iobus_out, iobus_wr,
    output iobus_in
  );
endinterface

// File: rtl/otter_sync_fifo.sv
// Single-clock FIFO; push into full is dropped even with a pop.
// Ports: clk, rst, push/din, pop/dout, full, empty, count.
module otter_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/otter_uart_io.sv
// Memory-mapped UART: TX FIFO + serializer, optional RX (OTTER_UART_RX_EN).
// Ports: clk, rst, bus (otter_io_if.slave), tx, rx, intr.
module otter_uart_io
  import otter_io_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  otter_io_if.slave bus,
  output logic      tx,
  input  logic      rx,
  output logic      intr
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int FW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CPB - 1);

  logic sel_tx, sel_st, sel_rx, wr_tx, wr_st;
  assign sel_tx = bus.iobus_addr == ADDR_TXDATA;
  assign sel_st = bus.iobus_addr == ADDR_STATUS;
  assign sel_rx = bus.iobus_addr == ADDR_RXDATA;
  assign wr_tx  = bus.iobus_wr & sel_tx;
  assign wr_st  = bus.iobus_wr & sel_st;

  logic          full, empty, tx_load, tx_ovf;
  logic [7:0]    fifo_q;
  logic [FW-1:0] fifo_cnt;

  otter_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .din   (bus.iobus_out[7:0]),
    .pop   (tx_load),
    .dout  (fifo_q),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst)                              tx_ovf <= 1'b0;
    else if (wr_tx & full)                tx_ovf <= 1'b1;
    else if (wr_st & bus.iobus_out[4])    tx_ovf <= 1'b0;
  end

  tx_state_t tx_st, tx_nx;
  logic [CW-1:0] tcnt, tcnt_nx;
  logic [2:0]    tbit, tbit_nx;
  logic [7:0]    tsh, tsh_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= TX_IDLE;
      tcnt  <= '0;
      tbit  <= '0;
      tsh   <= '0;
    end else begin
      tx_st <= tx_nx;
      tcnt  <= tcnt_nx;
      tbit  <= tbit_nx;
      tsh   <= tsh_nx;
    end
  end

  always_comb begin
    tx_nx   = tx_st;
    tcnt_nx = tcnt - CW'(1);
    tbit_nx = tbit;
    tsh_nx  = tsh;
    tx_load = 1'b0;
    unique case (tx_st)
      TX_IDLE: if (!empty) begin
        tx_load = 1'b1;
        tsh_nx  = fifo_q;
        tcnt_nx = RELOAD;
        tx_nx   = TX_START;
      end
      TX_START: if (tcnt == '0) begin
        tcnt_nx = RELOAD;
        tbit_nx = 3'd0;
        tx_nx   = TX_DATA;
      end
      TX_DATA: if (tcnt == '0) begin
        tcnt_nx = RELOAD;
        tsh_nx  = {1'b0, tsh[7:1]};
        tbit_nx = tbit + 3'd1;
        if (tbit == 3'd7) tx_nx = TX_STOP;
      end
      TX_STOP: if (tcnt == '0) begin
        // Chain straight into the next start bit: no idle gap.
        if (!empty) begin
          tx_load = 1'b1;
          tsh_nx  = fifo_q;
          tcnt_nx = RELOAD;
          tx_nx   = TX_START;
        end else begin
          tx_nx = TX_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (tx_st)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tsh[0];
      default:  ;
    endcase
  end

  logic       rx_valid, rx_ovr;
  logic [7:0] rx_data;

`ifdef OTTER_UART_RX_EN
  logic rx_s1, rx_s2, rx_s3;
  rx_state_t rx_st, rx_nx;
  logic [CW-1:0] rcnt, rcnt_nx;
  logic [2:0]    rbit, rbit_nx;
  logic [7:0]    rsh, rsh_nx;
  logic          rx_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_st    <= RX_IDLE;
      rcnt     <= '0;
      rbit     <= '0;
      rsh      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};
      rx_st <= rx_nx;
      rcnt  <= rcnt_nx;
      rbit  <= rbit_nx;
      rsh   <= rsh_nx;
      // A frame landing in the same cycle as a clear wins.
      if (rx_load) begin
        rx_data  <= rsh;
        rx_valid <= 1'b1;
      end else if (wr_st & bus.iobus_out[3]) begin
        rx_valid <= 1'b0;
      end
      if (rx_load & rx_valid)               rx_ovr <= 1'b1;
      else if (wr_st & bus.iobus_out[5])    rx_ovr <= 1'b0;
    end
  end

  always_comb begin
    rx_nx   = rx_st;
    rcnt_nx = rcnt - CW'(1);
    rbit_nx = rbit;
    rsh_nx  = rsh;
    rx_load = 1'b0;
    unique case (rx_st)
      RX_IDLE: if (rx_s3 & ~rx_s2) begin
        rcnt_nx = CW'(CPB / 2 - 1);
        rx_nx   = RX_START;
      end
      RX_START: if (rcnt == '0) begin
        rcnt_nx = RELOAD;
        rbit_nx = 3'd0;
        rx_nx   = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rcnt == '0) begin
        rcnt_nx = RELOAD;
        rsh_nx  = {rx_s2, rsh[7:1]};
        rbit_nx = rbit + 3'd1;
        if (rbit == 3'd7) rx_nx = RX_STOP;
      end
      RX_STOP: if (rcnt == '0) begin
        rx_load = rx_s2;
        rx_nx   = RX_IDLE;
      end
      default: ;
    endcase
  end
`else
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_valid  = 1'b0;
  assign rx_ovr    = 1'b0;
  assign rx_data   = '0;
`endif

  assign intr = rx_valid;

  logic unused_bits;
  assign unused_bits = ^{bus.iobus_out[31:8], fifo_cnt};

  logic [31:0] status, rdata;

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = full;
    status[ST_TX_EMPTY] = empty;
    status[ST_TX_BUSY]  = tx_st != TX_IDLE;
    status[ST_RX_VALID] = rx_valid;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_OVR]   = rx_ovr;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_st:  rdata = status;
      sel_rx:  rdata = {24'b0, rx_data};
      default: ;
    endcase
  end

  assign bus.iobus_in = rdata;
endmodule
